regfile_access_ctrl: RTL and testbench
======================================

REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

Interface
REQ-001 Parameter STREAK_MAX, default 2, range 1..3: consecutive write cycles allowed before a pending read is forced through.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low; deassertion takes effect at the next clk rising edge.
REQ-004 iss_valid  input  1  / iss_ready  output  1  issue handshake; transfer when both are high at a rising edge.
REQ-005 iss_rs1, iss_rs2  input  4 each  source register indices.
REQ-006 op_valid  output  1  / op_ready  input  1  operand handshake toward the execute stage.
REQ-007 op_a, op_b  output  16 each  registered operands for rs1 and rs2.
REQ-008 wb_valid  input  1  / wb_ready  output  1  writeback handshake; wb_rd  input  4, wb_data  input  16.
REQ-009 rf_rwa1  output  4  shared read-1/write address; rf_ra2  output  4  read-2 address.
REQ-010 rf_rd1, rf_rd2  input  16 each  combinational register-file read data; rf_we  output  1; rf_wd  output  16.

Function
REQ-011 Internal state: one-entry write buffer (wbuf_v, wbuf_rd, wbuf_data), operand register (op_valid, op_a, op_b), 2-bit write-streak counter.
REQ-012 Cycle type is combinational: WRITE when wbuf_v=1 and NOT (streak>=STREAK_MAX and iss_valid=1 and out_space=1); otherwise READ. out_space = !op_valid | op_ready.
REQ-013 WRITE cycle: rf_we=1, rf_rwa1=wbuf_rd, rf_wd=wbuf_data, iss_ready=0, rf_ra2=iss_rs2; the buffer entry is removed at the edge.
REQ-014 READ cycle: rf_we=0, rf_rwa1=iss_rs1, rf_ra2=iss_rs2, iss_ready=out_space.
REQ-015 wb_ready = !wbuf_v | (cycle is WRITE); an accepted writeback loads the buffer at the edge (same-cycle drain-and-refill permitted).
REQ-016 Issue accept (READ, iss_valid, iss_ready): at the edge op_valid<=1, op_a/op_b <= bypassed rf_rd1/rf_rd2.
REQ-017 Bypass source: wbuf entry if wbuf_v=1, else the writeback accepted this same cycle, else none; when the source register index equals rs1 (rs2), its data replaces rf_rd1 (rf_rd2); both operands may bypass.
REQ-018 Operand output: op_valid clears at the edge when op_ready=1 and no new issue is accepted; op_a/op_b hold when not loading.
REQ-019 Streak counter: +1 on each WRITE cycle, saturating at 3; cleared to 0 on every READ cycle.
REQ-020 Forced READ with wbuf_v=1: wb_ready=0, the buffer is held, and bypass uses the wbuf entry.
REQ-021 Writes are never lost or reordered; at most one register-file write per cycle; rf_we never asserts while wbuf_v=0.
REQ-022 Register index 0 has no special treatment.
REQ-023 iss_ready and wb_ready depend combinationally on iss_valid, op_ready and state only; neither depends on wb_valid.

Reset
REQ-024 While rst=0: op_valid=0, op_a=0, op_b=0, wbuf_v=0, wbuf_rd=0, wbuf_data=0, streak=0; rf_we=0 and wb_ready=1 follow combinationally.
REQ-025 Asserting rst mid-operation discards any buffered write and any held operand without a register-file write.

Verification
REQ-026 Reset -> op_valid=0, rf_we=0, wb_ready=1, iss_ready=1 with iss_valid=1, op_ready=0.
REQ-027 Register file preloaded with R3=0x1234 and R5=0x00FF; issue rs1=3, rs2=5 with wbuf empty and op_ready=1 -> after one edge op_valid=1, op_a=0x1234, op_b=0x00FF.
REQ-028 Writeback R3=0xBEEF and issue rs1=3, rs2=3 in the same cycle with wbuf empty -> op_a=op_b=0xBEEF; at the next edge rf_we=1, rf_rwa1=3, rf_wd=0xBEEF.
REQ-029 Continuous wb_valid to R1..R6 with iss_valid held (STREAK_MAX=2, op_ready=1) -> pattern W,W,R,W,W,R...; every write appears on rf_we in order; forced reads bypass from wbuf on an index match.
REQ-030 op_ready=0 with op_valid=1 and iss_valid=1 -> iss_ready=0, op_a/op_b stable, and buffered writes keep draining on consecutive cycles.
REQ-031 Assert rst while wbuf_v=1 and op_valid=1 -> both clear immediately; no rf_we pulse occurs after reset is released.

Source files
------------

// File: rtl/regfile_access_ctrl_if.sv
// Issue / operand / writeback / register-file port bundle for regfile_access_ctrl.
// slave  : the access controller's view.
// master : the surrounding pipeline and register file (testbench) view.
interface regfile_access_ctrl_if;
   logic        iss_valid;
   logic        iss_ready;
   logic [3:0]  iss_rs1;
   logic [3:0]  iss_rs2;

   logic        op_valid;
   logic        op_ready;
   logic [15:0] op_a;
   logic [15:0] op_b;

   logic        wb_valid;
   logic        wb_ready;
   logic [3:0]  wb_rd;
   logic [15:0] wb_data;

   logic [3:0]  rf_rwa1;
   logic [3:0]  rf_ra2;
   logic [15:0] rf_rd1;
   logic [15:0] rf_rd2;
   logic        rf_we;
   logic [15:0] rf_wd;

   modport slave (
      input  iss_valid, iss_rs1, iss_rs2, op_ready, wb_valid, wb_rd, wb_data, rf_rd1, rf_rd2,
      output iss_ready, op_valid, op_a, op_b, wb_ready, rf_rwa1, rf_ra2, rf_we, rf_wd
   );

   modport master (
      output iss_valid, iss_rs1, iss_rs2, op_ready, wb_valid, wb_rd, wb_data, rf_rd1, rf_rd2,
      input  iss_ready, op_valid, op_a, op_b, wb_ready, rf_rwa1, rf_ra2, rf_we, rf_wd
   );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Register-file access arbiter. Read port 1 and the write port share one
// address, so every cycle is either a READ (operand fetch) or a WRITE (drain
// the one-entry writeback buffer). Writes win by default; after STREAK_MAX
// consecutive writes a waiting issue is forced through, with the still
// buffered write bypassed into the operands.
module regfile_access_ctrl #(
   parameter int STREAK_MAX = 2
) (
   input logic                  clk,
   input logic                  rst,
   regfile_access_ctrl_if.slave bus
);
   localparam logic [1:0] STREAK_LIM = 2'(STREAK_MAX);

   typedef enum logic {
      CYC_READ  = 1'b0,
      CYC_WRITE = 1'b1
   } cyc_t;

   cyc_t        cyc;
   logic        out_space;
   logic        is_write;
   logic        iss_acc;
   logic        wb_acc;

   logic        wbuf_v;
   logic [3:0]  wbuf_rd;
   logic [15:0] wbuf_data;
   logic [1:0]  streak;

   logic        op_valid_q;
   logic [15:0] op_a_q;
   logic [15:0] op_b_q;

   logic        byp_v;
   logic [3:0]  byp_rd;
   logic [15:0] byp_data;
   logic [15:0] opnd_a;
   logic [15:0] opnd_b;

   // Cycle type: drain the buffer unless the streak limit lets a ready issue through.
   always_comb begin
      out_space = !op_valid_q || bus.op_ready;
      cyc       = CYC_READ;
      if (wbuf_v && !((streak >= STREAK_LIM) && bus.iss_valid && out_space))
         cyc = CYC_WRITE;
   end

   assign is_write    = (cyc == CYC_WRITE);
   assign bus.rf_we   = is_write;
   assign bus.rf_rwa1 = is_write ? wbuf_rd : bus.iss_rs1;
   assign bus.rf_ra2  = bus.iss_rs2;
   assign bus.rf_wd   = wbuf_data;
   assign bus.iss_ready = !is_write && out_space;
   assign bus.wb_ready  = !wbuf_v || is_write;
   assign bus.op_valid  = op_valid_q;
   assign bus.op_a      = op_a_q;
   assign bus.op_b      = op_b_q;

   assign iss_acc = bus.iss_valid && bus.iss_ready;
   assign wb_acc  = bus.wb_valid && bus.wb_ready;

   // Operand bypass: the buffered write is newest; otherwise a writeback landing this cycle.
   always_comb begin
      byp_v    = 1'b0;
      byp_rd   = 4'd0;
      byp_data = 16'd0;
      if (wbuf_v) begin
         byp_v    = 1'b1;
         byp_rd   = wbuf_rd;
         byp_data = wbuf_data;
      end else if (wb_acc) begin
         byp_v    = 1'b1;
         byp_rd   = bus.wb_rd;
         byp_data = bus.wb_data;
      end
      opnd_a = (byp_v && (byp_rd == bus.iss_rs1)) ? byp_data : bus.rf_rd1;
      opnd_b = (byp_v && (byp_rd == bus.iss_rs2)) ? byp_data : bus.rf_rd2;
   end

   // Write buffer: refill on accepted writeback, empty once drained.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wbuf_v    <= 1'b0;
         wbuf_rd   <= 4'd0;
         wbuf_data <= 16'd0;
      end else if (wb_acc) begin
         wbuf_v    <= 1'b1;
         wbuf_rd   <= bus.wb_rd;
         wbuf_data <= bus.wb_data;
      end else if (is_write) begin
         wbuf_v    <= 1'b0;
      end
   end

   // Write streak: counts back-to-back WRITE cycles, saturating, reset by any READ.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         streak <= 2'd0;
      else if (is_write)
         streak <= (streak == 2'd3) ? 2'd3 : streak + 2'd1;
      else
         streak <= 2'd0;
   end

   // Operand register: load on issue accept, drop when consumed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_valid_q <= 1'b0;
         op_a_q     <= 16'd0;
         op_b_q     <= 16'd0;
      end else if (iss_acc) begin
         op_valid_q <= 1'b1;
         op_a_q     <= opnd_a;
         op_b_q     <= opnd_b;
      end else if (bus.op_ready) begin
         op_valid_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: directed vector table, hand sequences for
// multi-cycle corners, and randomized traffic against an architectural model
// (register array with all accepted writebacks applied, plus an ordered queue
// of writes still owed to the register file).
module tb_regfile_access_ctrl;
   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   regfile_access_ctrl_if bus ();

   regfile_access_ctrl #(.STREAK_MAX(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] init_val(int i);
      if (i == 3) return 16'h1234;
      if (i == 5) return 16'h00FF;
      return 16'h1000 + 16'(i) * 16'h0101;
   endfunction

   // Register file: combinational read, write at the edge, reloaded while in reset.
   logic [15:0] rf [16];
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) rf[i] <= init_val(i);
      end else if (bus.rf_we) begin
         rf[bus.rf_rwa1] <= bus.rf_wd;
      end
   end
   assign bus.rf_rd1 = rf[bus.rf_rwa1];
   assign bus.rf_rd2 = rf[bus.rf_ra2];

   typedef struct {
      logic [3:0]  rd;
      logic [15:0] d;
   } wr_t;

   logic [15:0] arch [16];
   wr_t         wq [$];
   logic        exp_v;
   logic [15:0] exp_a;
   logic [15:0] exp_b;
   int          stall;

   task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) arch[i] = init_val(i);
      wq.delete();
      exp_v = 1'b0;
      exp_a = 16'd0;
      exp_b = 16'd0;
      stall = 0;
   endtask

   task automatic drive(logic iv, logic [3:0] rs1, logic [3:0] rs2, logic ordy,
                        logic wv, logic [3:0] wrd, logic [15:0] wd);
      bus.iss_valid = iv;
      bus.iss_rs1   = rs1;
      bus.iss_rs2   = rs2;
      bus.op_ready  = ordy;
      bus.wb_valid  = wv;
      bus.wb_rd     = wrd;
      bus.wb_data   = wd;
   endtask

   // One clock with model checks; entered shortly after a rising edge, leaves 1 unit after the next.
   task automatic cycle();
      logic wb_acc;
      logic iss_acc;
      #2;
      wb_acc  = bus.wb_valid && bus.wb_ready;
      iss_acc = bus.iss_valid && bus.iss_ready;
      if (bus.rf_we) begin
         n_tests++;
         if (wq.size() == 0) begin
            n_fail++;
            $display("FAIL rf_we_no_pending: got rf_we=1 with no owed write, expected 0 (t=%0t)", $time);
         end else begin
            chk("write_order_addr", 16'(bus.rf_rwa1), 16'(wq[0].rd));
            chk("write_order_data", bus.rf_wd, wq[0].d);
            void'(wq.pop_front());
         end
      end
      if (wq.size() > 0) begin
         stall = bus.rf_we ? 0 : stall + 1;
         chk("write_starved", 16'(stall >= 2), 16'd0);
      end else begin
         stall = 0;
      end
      if (exp_v && !bus.op_ready) chk("iss_ready_while_full", 16'(bus.iss_ready), 16'd0);
      if (bus.rf_we) chk("iss_ready_on_write", 16'(bus.iss_ready), 16'd0);
      if (wb_acc) begin
         arch[bus.wb_rd] = bus.wb_data;
         wq.push_back('{rd: bus.wb_rd, d: bus.wb_data});
      end
      if (iss_acc) begin
         exp_v = 1'b1;
         exp_a = arch[bus.iss_rs1];
         exp_b = arch[bus.iss_rs2];
      end else if (bus.op_ready) begin
         exp_v = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("op_valid", 16'(bus.op_valid), 16'(exp_v));
      if (exp_v) begin
         chk("op_a", bus.op_a, exp_a);
         chk("op_b", bus.op_b, exp_b);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 16'd0);
      #1;
      chk("rst_op_valid", 16'(bus.op_valid), 16'd0);
      chk("rst_rf_we", 16'(bus.rf_we), 16'd0);
      chk("rst_wb_ready", 16'(bus.wb_ready), 16'd1);
      chk("rst_iss_ready", 16'(bus.iss_ready), 16'd1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 16'd0);
   endtask

   typedef struct {
      logic        iv;
      logic [3:0]  rs1;
      logic [3:0]  rs2;
      logic        ordy;
      logic        wv;
      logic [3:0]  wrd;
      logic [15:0] wd;
      logic        e_ir;
      logic        e_wr;
      logic        e_we;
      logic [3:0]  e_rwa1;
      logic [15:0] e_wd;
      logic        e_ov;
      logic [15:0] e_a;
      logic [15:0] e_b;
   } vec_t;

   vec_t vecs [11];

   initial begin
      n_tests = 0;
      n_fail  = 0;
      model_reset();

      // Continuous writebacks R1..R6 with issue held: W,W,R pattern and forced-read bypass.
      vecs[0]  = '{1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd1, 16'hA001, 1'b1, 1'b1, 1'b0, 4'd1, 16'h0000, 1'b1, 16'hA001, 16'h1202};
      vecs[1]  = '{1'b1, 4'd3, 4'd2, 1'b1, 1'b1, 4'd2, 16'hA002, 1'b0, 1'b1, 1'b1, 4'd1, 16'hA001, 1'b0, 16'h0000, 16'h0000};
      vecs[2]  = '{1'b1, 4'd3, 4'd2, 1'b1, 1'b1, 4'd3, 16'hA003, 1'b0, 1'b1, 1'b1, 4'd2, 16'hA002, 1'b0, 16'h0000, 16'h0000};
      vecs[3]  = '{1'b1, 4'd3, 4'd2, 1'b1, 1'b1, 4'd4, 16'hA004, 1'b1, 1'b0, 1'b0, 4'd3, 16'h0000, 1'b1, 16'hA003, 16'hA002};
      vecs[4]  = '{1'b1, 4'd5, 4'd5, 1'b1, 1'b1, 4'd4, 16'hA004, 1'b0, 1'b1, 1'b1, 4'd3, 16'hA003, 1'b0, 16'h0000, 16'h0000};
      vecs[5]  = '{1'b1, 4'd5, 4'd5, 1'b1, 1'b1, 4'd5, 16'hA005, 1'b0, 1'b1, 1'b1, 4'd4, 16'hA004, 1'b0, 16'h0000, 16'h0000};
      vecs[6]  = '{1'b1, 4'd5, 4'd5, 1'b1, 1'b1, 4'd6, 16'hA006, 1'b1, 1'b0, 1'b0, 4'd5, 16'h0000, 1'b1, 16'hA005, 16'hA005};
      vecs[7]  = '{1'b1, 4'd6, 4'd1, 1'b1, 1'b1, 4'd6, 16'hA006, 1'b0, 1'b1, 1'b1, 4'd5, 16'hA005, 1'b0, 16'h0000, 16'h0000};
      vecs[8]  = '{1'b1, 4'd6, 4'd1, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 4'd6, 16'hA006, 1'b0, 16'h0000, 16'h0000};
      vecs[9]  = '{1'b1, 4'd6, 4'd1, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd6, 16'h0000, 1'b1, 16'hA006, 16'hA001};
      vecs[10] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 16'h0000};

      do_reset();
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].iv, vecs[i].rs1, vecs[i].rs2, vecs[i].ordy, vecs[i].wv, vecs[i].wrd, vecs[i].wd);
         #1;
         chk($sformatf("vec%0d_iss_ready", i), 16'(bus.iss_ready), 16'(vecs[i].e_ir));
         chk($sformatf("vec%0d_wb_ready", i), 16'(bus.wb_ready), 16'(vecs[i].e_wr));
         chk($sformatf("vec%0d_rf_we", i), 16'(bus.rf_we), 16'(vecs[i].e_we));
         chk($sformatf("vec%0d_rf_rwa1", i), 16'(bus.rf_rwa1), 16'(vecs[i].e_rwa1));
         if (vecs[i].e_we) chk($sformatf("vec%0d_rf_wd", i), bus.rf_wd, vecs[i].e_wd);
         cycle();
         chk($sformatf("vec%0d_op_valid", i), 16'(bus.op_valid), 16'(vecs[i].e_ov));
         if (vecs[i].e_ov) begin
            chk($sformatf("vec%0d_op_a", i), bus.op_a, vecs[i].e_a);
            chk($sformatf("vec%0d_op_b", i), bus.op_b, vecs[i].e_b);
         end
      end

      // Plain operand fetch from the preloaded file.
      do_reset();
      drive(1'b1, 4'd3, 4'd5, 1'b1, 1'b0, 4'd0, 16'd0);
      cycle();
      chk("fetch_op_valid", 16'(bus.op_valid), 16'd1);
      chk("fetch_op_a", bus.op_a, 16'h1234);
      chk("fetch_op_b", bus.op_b, 16'h00FF);

      // Same-cycle writeback bypassed into both operands, then drained.
      do_reset();
      drive(1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 4'd3, 16'hBEEF);
      #1;
      chk("samecyc_iss_ready", 16'(bus.iss_ready), 16'd1);
      chk("samecyc_wb_ready", 16'(bus.wb_ready), 16'd1);
      cycle();
      chk("samecyc_op_a", bus.op_a, 16'hBEEF);
      chk("samecyc_op_b", bus.op_b, 16'hBEEF);
      drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 16'd0);
      #1;
      chk("samecyc_rf_we", 16'(bus.rf_we), 16'd1);
      chk("samecyc_rf_rwa1", 16'(bus.rf_rwa1), 16'd3);
      chk("samecyc_rf_wd", bus.rf_wd, 16'hBEEF);
      cycle();

      // Output back-pressure: operand held, buffered writes keep draining.
      do_reset();
      drive(1'b1, 4'd3, 4'd5, 1'b0, 1'b1, 4'd7, 16'h7777);
      #1;
      chk("bp0_iss_ready", 16'(bus.iss_ready), 16'd1);
      cycle();
      drive(1'b1, 4'd7, 4'd8, 1'b0, 1'b1, 4'd8, 16'h8888);
      #1;
      chk("bp1_iss_ready", 16'(bus.iss_ready), 16'd0);
      chk("bp1_rf_we", 16'(bus.rf_we), 16'd1);
      chk("bp1_rf_rwa1", 16'(bus.rf_rwa1), 16'd7);
      cycle();
      chk("bp1_op_a", bus.op_a, 16'h1234);
      chk("bp1_op_b", bus.op_b, 16'h00FF);
      bus.wb_valid = 1'b0;
      #1;
      chk("bp2_iss_ready", 16'(bus.iss_ready), 16'd0);
      chk("bp2_rf_we", 16'(bus.rf_we), 16'd1);
      chk("bp2_rf_rwa1", 16'(bus.rf_rwa1), 16'd8);
      cycle();
      chk("bp2_op_a", bus.op_a, 16'h1234);
      #1;
      chk("bp3_iss_ready", 16'(bus.iss_ready), 16'd0);
      chk("bp3_rf_we", 16'(bus.rf_we), 16'd0);
      cycle();
      chk("bp3_op_b", bus.op_b, 16'h00FF);
      bus.op_ready = 1'b1;
      #1;
      chk("bp4_iss_ready", 16'(bus.iss_ready), 16'd1);
      cycle();
      chk("bp4_op_a", bus.op_a, 16'h7777);
      chk("bp4_op_b", bus.op_b, 16'h8888);

      // Reset mid-operation drops the buffered write and the held operand.
      do_reset();
      drive(1'b1, 4'd1, 4'd2, 1'b0, 1'b1, 4'd9, 16'h9999);
      cycle();
      rst = 1'b0;
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 16'd0);
      #1;
      chk("midrst_op_valid", 16'(bus.op_valid), 16'd0);
      chk("midrst_op_a", bus.op_a, 16'd0);
      chk("midrst_op_b", bus.op_b, 16'd0);
      chk("midrst_rf_we", 16'(bus.rf_we), 16'd0);
      chk("midrst_wb_ready", 16'(bus.wb_ready), 16'd1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      bus.op_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("postrst_rf_we", 16'(bus.rf_we), 16'd0);
         cycle();
      end

      // Randomized traffic against the architectural model.
      for (int ph = 0; ph < 3; ph++) begin
         int p_iv;
         int p_or;
         int p_wv;
         p_iv = (ph == 0) ? 50 : (ph == 1) ? 90 : 70;
         p_or = (ph == 0) ? 80 : (ph == 1) ? 95 : 30;
         p_wv = (ph == 0) ? 50 : (ph == 1) ? 95 : 80;
         do_reset();
         for (int n = 0; n < 1000; n++) begin
            drive(1'($urandom_range(0, 99) < p_iv), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                  1'($urandom_range(0, 99) < p_or), 1'($urandom_range(0, 99) < p_wv),
                  4'($urandom_range(0, 7)), 16'($urandom));
            cycle();
         end
         drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 16'd0);
         repeat (4) cycle();
         chk("drain_pending", 16'(wq.size()), 16'd0);
         for (int i = 0; i < 16; i++) chk($sformatf("final_r%0d", i), rf[i], arch[i]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
